tod_bcd_clock: RTL

- Time-of-day keeper directly downstream of the PLL/phase-accumulator one-pulse-per-second generator, in the 39.75 MHz s_clk domain.
- Consumes the single-cycle pps strobe and maintains packed-BCD hours:minutes:seconds, in 24 h or 12 h AM/PM format.
- Emits minute, hour and day rollover strobes for LED and display logic.
- Accepts a time-set request over a valid/ready handshake, with range checking.

---
 rtl/tod_bcd_clock.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tod_bcd_clock.sv
// Time-of-day keeper: packed-BCD hh:mm:ss advanced by a one-cycle pps strobe,
// with rollover strobes and a range-checked set request (valid/ready).
//
// state | meaning
// IDLE  | ready for a set request; time advances on pps
// CHECK | latched request being validated; loads or rejects on exit
module tod_bcd_clock #(
  parameter bit H24 = 1'b1
) (
  input  logic        s_clk,
  input  logic        s_reset,
  input  logic        i_pps,
  input  logic        i_set_valid,
  output logic        o_set_ready,
  input  logic [23:0] i_set_time,
  input  logic        i_set_pm,
  output logic [7:0]  o_hh,
  output logic [7:0]  o_mm,
  output logic [7:0]  o_ss,
  output logic        o_pm,
  output logic        o_min_stb,
  output logic        o_hr_stb,
  output logic        o_day_stb,
  output logic        o_set_ack,
  output logic        o_set_err
);

  typedef enum logic {IDLE, CHECK} set_state_e;

  localparam logic [7:0] RST_HH = H24 ? 8'h00 : 8'h12;

  set_state_e  state, state_nxt;
  logic [23:0] set_time_q;
  logic        set_pm_q;
  logic        accept;
  logic        set_ok;

  logic [7:0]  ss_nxt, mm_nxt, mm_inc, hh_nxt;
  logic        sec_wrap, min_wrap, hr_wrap, day_wrap, pm_nxt;

  // Minutes/seconds increment: {carry, value}, 59 wraps to 00 with carry.
  function automatic logic [8:0] inc_60(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return 9'h100;
  endfunction

  // Plain two-digit BCD increment, no wrap.
  function automatic logic [7:0] inc_bcd(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    else
      return {v[7:4] + 4'd1, 4'd0};
  endfunction

  assign o_set_ready = (state == IDLE);
  assign accept      = i_set_valid && o_set_ready;

  // Set FSM state register.
  always_ff @(posedge s_clk) begin
    if (s_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Set FSM next state: one validation cycle, then back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_set_valid) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Range check of the latched request; numeric compares are safe once every nibble is <= 9.
  always_comb begin
    set_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (set_time_q[i*4 +: 4] > 4'd9) set_ok = 1'b0;
    if (set_time_q[7:0] > 8'h59)  set_ok = 1'b0;
    if (set_time_q[15:8] > 8'h59) set_ok = 1'b0;
    if (H24) begin
      if (set_time_q[23:16] > 8'h23) set_ok = 1'b0;
    end else begin
      if (set_time_q[23:16] < 8'h01 || set_time_q[23:16] > 8'h12) set_ok = 1'b0;
    end
  end

  // Next time on a pps, with the carries that drive the rollover strobes.
  always_comb begin
    {sec_wrap, ss_nxt} = inc_60(o_ss);
    {min_wrap, mm_inc} = inc_60(o_mm);
    mm_nxt   = sec_wrap ? mm_inc : o_mm;
    hr_wrap  = sec_wrap && min_wrap;
    hh_nxt   = o_hh;
    pm_nxt   = o_pm;
    day_wrap = 1'b0;
    if (hr_wrap) begin
      if (H24) begin
        if (o_hh == 8'h23) begin
          hh_nxt   = 8'h00;
          day_wrap = 1'b1;
        end else begin
          hh_nxt = inc_bcd(o_hh);
        end
      end else begin
        if (o_hh == 8'h12) begin
          hh_nxt = 8'h01;
        end else if (o_hh == 8'h11) begin
          hh_nxt   = 8'h12;
          pm_nxt   = ~o_pm;
          day_wrap = o_pm;
        end else begin
          hh_nxt = inc_bcd(o_hh);
        end
      end
    end
  end

  // Time registers, request latch and strobes; a valid load in CHECK overrides a pps.
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      o_hh       <= RST_HH;
      o_mm       <= 8'h00;
      o_ss       <= 8'h00;
      o_pm       <= 1'b0;
      o_min_stb  <= 1'b0;
      o_hr_stb   <= 1'b0;
      o_day_stb  <= 1'b0;
      o_set_ack  <= 1'b0;
      o_set_err  <= 1'b0;
      set_time_q <= 24'h0;
      set_pm_q   <= 1'b0;
    end else begin
      o_min_stb <= 1'b0;
      o_hr_stb  <= 1'b0;
      o_day_stb <= 1'b0;
      o_set_ack <= 1'b0;
      o_set_err <= 1'b0;
      if (accept) begin
        set_time_q <= i_set_time;
        set_pm_q   <= i_set_pm;
      end
      if (state == CHECK && set_ok) begin
        o_hh      <= set_time_q[23:16];
        o_mm      <= set_time_q[15:8];
        o_ss      <= set_time_q[7:0];
        o_pm      <= H24 ? 1'b0 : set_pm_q;
        o_set_ack <= 1'b1;
      end else begin
        if (state == CHECK) o_set_err <= 1'b1;
        if (i_pps) begin
          o_ss      <= ss_nxt;
          o_mm      <= mm_nxt;
          o_hh      <= hh_nxt;
          o_pm      <= pm_nxt;
          o_min_stb <= sec_wrap;
          o_hr_stb  <= hr_wrap;
          o_day_stb <= day_wrap;
        end
      end
    end
  end

endmodule
